// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   state_t  : soft-clear FSM state (IDLE accepts traffic, CLEAR sweeps zeros)
//   DEF_*    : default width/depth
//   wr_pick  : write-port match with port-1 priority, used by the read bypass
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int unsigned DEF_XLEN  = 64;
  localparam int unsigned DEF_NREGS = 32;

  // Returns {hit, sel}: hit = some enabled write port targets ra,
  // sel = 1 when port 1 is the winner (port 1 beats port 0).
  // Address 0 never hits when it is the hardwired zero register.
  function automatic logic [1:0] wr_pick(input logic [1:0] en,
                                         input logic [31:0] a0,
                                         input logic [31:0] a1,
                                         input logic [31:0] ra,
                                         input logic zero_reg);
    logic h0;
    logic h1;
    logic z;
    z  = zero_reg && (ra == '0);
    h0 = en[0] && (a0 == ra) && !z;
    h1 = en[1] && (a1 == ra) && !z;
    return {h0 | h1, h1};
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the register file.
//   rd_addr/rd_data/rd_busy : NUM_RD combinational read ports (packed)
//   wr_en/wr_addr/wr_data   : two write ports (packed)
//   sb_set/sb_addr          : scoreboard busy set
//   clear_req/ready         : soft-clear request, IDLE indication
// master = pipeline side, slave = register file.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [1:0]             wr_en;
  logic [2*AW-1:0]        wr_addr;
  logic [2*XLEN-1:0]      wr_data;
  logic                   sb_set;
  logic [AW-1:0]          sb_addr;
  logic                   clear_req;
  logic                   ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clear_req,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clear_req,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   clk, reset : clock, async active-low reset
//   flush      : clear every busy bit (entry into soft clear)
//   set_en/set_addr : mark a register busy
//   wr_en/wr_addr   : writeback of a register clears its busy bit
//   rd_addr/rd_busy : registered busy bit of each read port's register
module regfile_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic [1:0]           wr_en,
  input  logic [2*AW-1:0]      wr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Clear first, then set, so a same-cycle set overrides the writeback clear.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned a = 0; a < NREGS; a++) begin
      if ((wr_en[0] && wr_addr[0 +: AW] == AW'(a)) ||
          (wr_en[1] && wr_addr[AW +: AW] == AW'(a)))
        busy_nxt[a] = 1'b0;
      if (set_en && set_addr == AW'(a))
        busy_nxt[a] = 1'b1;
    end
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy <= '0;
    else if (flush)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++)
      rd_busy[i] = busy[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with busy scoreboard
// and a sequenced soft clear.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : regfile_mp_if slave (read ports, two write ports, scoreboard
//           set, clear request, ready)
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);

  logic [XLEN-1:0] regs [NREGS];
  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic            ready_q;

  logic [AW-1:0]   wa0;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd0;
  logic [XLEN-1:0] wd1;
  logic [1:0]      wr_en_g;
  logic            sb_set_g;
  logic            flush;
  logic [NUM_RD-1:0] sb_busy;

  assign wa0 = bus.wr_addr[0 +: AW];
  assign wa1 = bus.wr_addr[AW +: AW];
  assign wd0 = bus.wr_data[0 +: XLEN];
  assign wd1 = bus.wr_data[XLEN +: XLEN];

  // Traffic is only accepted in IDLE; nothing is queued during CLEAR.
  assign wr_en_g  = ready_q ? bus.wr_en : 2'b00;
  assign sb_set_g = ready_q && bus.sb_set;
  assign flush    = ready_q && bus.clear_req;
  assign bus.ready = ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned a = 0; a < NREGS; a++)
        regs[a] <= '0;
      state   <= IDLE;
      clr_idx <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // Port 1 is assigned last so it wins an address collision.
          if (wr_en_g[0] && !(ZERO_REG != 0 && wa0 == '0))
            regs[wa0] <= wd0;
          if (wr_en_g[1] && !(ZERO_REG != 0 && wa1 == '0))
            regs[wa1] <= wd1;
          if (bus.clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          regs[clr_idx] <= '0;
          clr_idx       <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREGS - 1)) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic [1:0]      pick;
    bus.rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra   = bus.rd_addr[i*AW +: AW];
      d    = regs[ra];
      pick = wr_pick(wr_en_g, 32'(wa0), 32'(wa1), 32'(ra), ZERO_REG != 0);
      if (ZERO_REG != 0 && ra == '0)
        d = '0;
      else if (BYPASS != 0 && pick[1])
        d = pick[0] ? wd1 : wd0;
      if (state == CLEAR)
        d = '0;
      bus.rd_data[i*XLEN +: XLEN] = d;
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .set_en  (sb_set_g),
    .set_addr(bus.sb_addr),
    .wr_en   (wr_en_g),
    .wr_addr (bus.wr_addr),
    .rd_addr (bus.rd_addr),
    .rd_busy (sb_busy)
  );

  assign bus.rd_busy = (state == CLEAR) ? '0 : sb_busy;

endmodule
